// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encodings and
// synchroniser depth.
package button_conditioner_pkg;

  localparam int BUTTON_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PRESS_WAIT   = 3'd1,
    ST_HELD         = 3'd2,
    ST_LONG_HELD    = 3'd3,
    ST_RELEASE_WAIT = 3'd4
  } btn_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs, with an asynchronous
// active-high reset to a selectable value.
module sync_2ff
  import button_conditioner_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [BUTTON_SYNC_STAGES-1:0] chain_q;
  logic [BUTTON_SYNC_STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[BUTTON_SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {BUTTON_SYNC_STAGES{RST_VAL}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[BUTTON_SYNC_STAGES-1];

endmodule

// File: rtl/button_conditioner.sv
// Turns a bouncing push-button into a debounced level, press/release/long-press
// pulses and a long-press reset request held until release.
//
// state           | meaning
// ST_IDLE         | released, debounce counter idle
// ST_PRESS_WAIT   | synchronised input high, debounce window running
// ST_HELD         | debounced press, long threshold not yet reached
// ST_LONG_HELD    | debounced press past the long threshold
// ST_RELEASE_WAIT | synchronised input low while pressed, window running
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_BITS = 16,
  parameter int LONG_BITS     = 22,
  parameter int ACTIVE_LOW    = 0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN,
  output logic level,
  output logic pressed,
  output logic released,
  output logic long,
  output logic rst_req
);

  localparam logic                     INVERT      = (ACTIVE_LOW != 0);
  localparam logic [DEBOUNCE_BITS-1:0] DEB_ONE     = DEBOUNCE_BITS'(1);
  localparam logic [LONG_BITS-1:0]     HOLD_ONE    = LONG_BITS'(1);
  localparam logic [LONG_BITS-1:0]     HOLD_PRE_TC = {{(LONG_BITS-1){1'b1}}, 1'b0};

  logic b;
  logic s;

  btn_state_e               state_q, state_d;
  logic [DEBOUNCE_BITS-1:0] deb_q, deb_d;
  logic [LONG_BITS-1:0]     hold_q, hold_d;
  logic                     level_q, level_d;
  logic                     pressed_q, pressed_d;
  logic                     released_q, released_d;
  logic                     long_q, long_d;
  logic                     rst_req_q, rst_req_d;
  logic                     from_long_q, from_long_d;

  logic mismatch;
  logic win_done;
  logic rise;
  logic fall;

  assign b = BTN ^ INVERT;

  sync_2ff #(.RST_VAL(1'b0)) u_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (b),
    .q   (s)
  );

  // Any cycle where s agrees with level restarts the window from zero.
  always_comb begin
    mismatch   = (s != level_q);
    win_done   = mismatch && (&deb_q);
    rise       = win_done && !level_q;
    fall       = win_done && level_q;
    level_d    = level_q ^ win_done;
    deb_d      = (mismatch && !win_done) ? deb_q + DEB_ONE : '0;
    hold_d     = '0;
    if (level_q && !fall) begin
      hold_d = (&hold_q) ? hold_q : hold_q + HOLD_ONE;
    end
    long_d     = level_q && !fall && (hold_q == HOLD_PRE_TC);
    pressed_d  = rise;
    released_d = fall;
    rst_req_d  = fall ? 1'b0 : (rst_req_q | long_d);
  end

  always_comb begin
    state_d     = state_q;
    from_long_d = from_long_q;
    case (state_q)
      ST_IDLE: begin
        if (s) state_d = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (rise)    state_d = ST_HELD;
        else if (!s) state_d = ST_IDLE;
      end
      ST_HELD: begin
        if (!s) begin
          state_d     = ST_RELEASE_WAIT;
          from_long_d = long_d;
        end else if (long_d) begin
          state_d = ST_LONG_HELD;
        end
      end
      ST_LONG_HELD: begin
        if (!s) begin
          state_d     = ST_RELEASE_WAIT;
          from_long_d = 1'b1;
        end
      end
      ST_RELEASE_WAIT: begin
        // The hold counter keeps running here, so the long threshold can pass.
        if (fall) begin
          state_d     = ST_IDLE;
          from_long_d = 1'b0;
        end else if (s) begin
          state_d     = (from_long_q || long_d) ? ST_LONG_HELD : ST_HELD;
          from_long_d = 1'b0;
        end else if (long_d) begin
          from_long_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        from_long_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      deb_q       <= '0;
      hold_q      <= '0;
      level_q     <= 1'b0;
      pressed_q   <= 1'b0;
      released_q  <= 1'b0;
      long_q      <= 1'b0;
      rst_req_q   <= 1'b0;
      from_long_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      deb_q       <= deb_d;
      hold_q      <= hold_d;
      level_q     <= level_d;
      pressed_q   <= pressed_d;
      released_q  <= released_d;
      long_q      <= long_d;
      rst_req_q   <= rst_req_d;
      from_long_q <= from_long_d;
    end
  end

  assign level    = level_q;
  assign pressed  = pressed_q;
  assign released = released_q;
  assign long     = long_q;
  assign rst_req  = rst_req_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed timing scenarios plus random bouncing
// input, checked every cycle against a run-length reference model.
module tb_button_conditioner;

  localparam int DB         = 4;
  localparam int LB         = 6;
  localparam int WIN        = 1 << DB;
  localparam int LONG_EDGES = (1 << LB) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic btn_n;
  logic lvl_a, prs_a, rel_a, lng_a, rrq_a;
  logic lvl_b, prs_b, rel_b, lng_b, rrq_b;

  assign btn_n = ~btn;

  button_conditioner #(.DEBOUNCE_BITS(DB), .LONG_BITS(LB), .ACTIVE_LOW(0)) dut_a (
    .CLK(clk), .RESET(rst), .BTN(btn),
    .level(lvl_a), .pressed(prs_a), .released(rel_a), .long(lng_a), .rst_req(rrq_a)
  );

  button_conditioner #(.DEBOUNCE_BITS(DB), .LONG_BITS(LB), .ACTIVE_LOW(1)) dut_b (
    .CLK(clk), .RESET(rst), .BTN(btn_n),
    .level(lvl_b), .pressed(prs_b), .released(rel_b), .long(lng_b), .rst_req(rrq_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: s is the pin value two edges old; level flips after WIN
  // consecutive disagreeing cycles; long fires LONG_EDGES edges after the rise.
  logic m_pipe[$];
  int   m_run, m_held;
  logic m_lvl, m_prs, m_rel, m_lng, m_rrq;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pipe = '{1'b0, 1'b0};
    m_run  = 0;
    m_held = 0;
    m_lvl  = 1'b0;
    m_prs  = 1'b0;
    m_rel  = 1'b0;
    m_lng  = 1'b0;
    m_rrq  = 1'b0;
  endtask

  task automatic model_edge(input logic b);
    logic s;
    if (rst) begin
      model_reset();
      return;
    end
    s = m_pipe.pop_front();
    m_pipe.push_back(b);
    m_prs = 1'b0;
    m_rel = 1'b0;
    m_lng = 1'b0;
    m_run = (s != m_lvl) ? m_run + 1 : 0;
    if (m_run == WIN) begin
      m_run  = 0;
      m_lvl  = ~m_lvl;
      m_held = 0;
      if (m_lvl) begin
        m_prs = 1'b1;
      end else begin
        m_rel = 1'b1;
        m_rrq = 1'b0;
      end
    end else if (m_lvl) begin
      m_held++;
      if (m_held == LONG_EDGES) begin
        m_lng = 1'b1;
        m_rrq = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".level"},       lvl_a, m_lvl);
    check({tag, ".pressed"},     prs_a, m_prs);
    check({tag, ".released"},    rel_a, m_rel);
    check({tag, ".long"},        lng_a, m_lng);
    check({tag, ".rst_req"},     rrq_a, m_rrq);
    check({tag, ".al_level"},    lvl_b, m_lvl);
    check({tag, ".al_pressed"},  prs_b, m_prs);
    check({tag, ".al_released"}, rel_b, m_rel);
    check({tag, ".al_long"},     lng_b, m_lng);
    check({tag, ".al_rst_req"},  rrq_b, m_rrq);
  endtask

  // Called 1 time unit after an edge; drives the pin, takes one edge, compares.
  task automatic step(input logic b);
    btn = b;
    @(posedge clk);
    model_edge(b);
    #1;
    compare_all("cyc");
  endtask

  task automatic apply_reset(input logic b);
    btn = b;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("async_reset");
    step(b);
    rst = 1'b0;
  endtask

  task automatic wait_press(input string tag);
    int n;
    n = 0;
    for (int i = 1; i <= WIN + 22 && n == 0; i++) begin
      step(1'b1);
      if (prs_a) n = i;
    end
    check_int(tag, n, WIN + 2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   fp, fpb, fl, np, nrel, nlng, nrr, k, len;
    logic v;

    model_reset();
    rst = 1'b1;
    btn = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0);
    step(1'b0);
    check("reset.level", lvl_a, 1'b0);
    check("reset.rst_req", rrq_a, 1'b0);
    check("reset.al_level", lvl_b, 1'b0);
    rst = 1'b0;

    // Clean press, both polarities.
    apply_reset(1'b0);
    fp = 0; fpb = 0; fl = 0; np = 0; nrel = 0;
    for (int i = 1; i <= 100; i++) begin
      step(1'b1);
      if (prs_a) begin
        np++;
        if (fp == 0) fp = i;
      end
      if (prs_b && fpb == 0) fpb = i;
      if (lng_a && fl == 0) fl = i;
      if (rel_a) nrel++;
    end
    check_int("clean.pressed_edge", fp, WIN + 2);
    check_int("clean.pressed_width", np, 1);
    check_int("clean.long_edge", fl, WIN + 2 + LONG_EDGES);
    check_int("clean.released_count", nrel, 0);
    check_int("active_low.pressed_edge", fpb, WIN + 2);
    check("clean.rst_req_held", rrq_a, 1'b1);
    check("active_low.rst_req_held", rrq_b, 1'b1);
    repeat (30) step(1'b0);

    // Bounce rejection.
    apply_reset(1'b0);
    k = 0;
    for (int i = 0; i < 60; i++) begin
      step(((i / 5) % 2) == 0);
      if (lvl_a | prs_a | rel_a | lng_a) k++;
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      if (lvl_a | prs_a | rel_a | lng_a) k++;
    end
    check_int("bounce.activity", k, 0);

    // Short press.
    apply_reset(1'b0);
    fp = 0; fl = 0; nrel = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1'b1);
      if (prs_a && fp == 0) fp = i;
      if (lng_a) fl = i;
    end
    for (int i = 1; i <= 40; i++) begin
      step(1'b0);
      if (rel_a && nrel == 0) nrel = i;
      if (lng_a) fl = i;
    end
    check_int("short.pressed_edge", fp, WIN + 2);
    check_int("short.released_delay", nrel, WIN + 2);
    check_int("short.long_edge", fl, 0);

    // Release bounce while held.
    apply_reset(1'b0);
    fl = 0; k = 0;
    for (int i = 1; i <= 100; i++) begin
      step(!(i >= 40 && i < 50));
      if (i >= WIN + 2 && !lvl_a) k++;
      if (rel_a) k++;
      if (lng_a && fl == 0) fl = i;
    end
    check_int("rbounce.drops", k, 0);
    check_int("rbounce.long_edge", fl, WIN + 2 + LONG_EDGES);
    repeat (30) step(1'b0);

    // Release completing on the long edge, then one edge later.
    for (int hold_len = LONG_EDGES; hold_len <= LONG_EDGES + 1; hold_len++) begin
      apply_reset(1'b0);
      nlng = 0; nrr = 0; nrel = 0;
      for (int i = 1; i <= hold_len + 40; i++) begin
        step(i <= hold_len);
        if (lng_a) nlng = i;
        if (rrq_a) nrr++;
        if (rel_a) nrel = i;
      end
      check_int("simul.released_edge", nrel, hold_len + WIN + 2);
      check_int("simul.long_edge", nlng, (hold_len == LONG_EDGES) ? 0 : WIN + 2 + LONG_EDGES);
      check_int("simul.rst_req_cycles", nrr, (hold_len == LONG_EDGES) ? 0 : 1);
    end

    // Mid-operation resets: in the press window, during a hold, on a pressed pulse.
    apply_reset(1'b0);
    repeat (10) step(1'b1);
    apply_reset(1'b1);
    wait_press("midrst.window_repress");
    repeat (22) step(1'b1);
    check("midrst.level_before", lvl_a, 1'b1);
    apply_reset(1'b1);
    wait_press("midrst.hold_repress");
    check("trunc.pressed_before", prs_a, 1'b1);
    apply_reset(1'b1);
    check("trunc.pressed_after", prs_a, 1'b0);
    wait_press("trunc.repress");
    repeat (20) step(1'b0);

    // Random bouncing segments with occasional resets.
    for (int r = 0; r < 5; r++) begin
      apply_reset(1'b0);
      v = 1'b0;
      for (int seg = 0; seg < 50; seg++) begin
        v   = ($urandom_range(0, 3) == 0) ? v : ~v;
        len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(50, 150))
                                          : int'($urandom_range(1, 22));
        for (int c = 0; c < len; c++) step(v);
        if ($urandom_range(0, 20) == 0) apply_reset(v);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
